cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  level; leaves IDLE when high.
REQ-004 SHALL have port opcode  input  8  IR output, i.e. the instruction word bits [15:8].
REQ-005 SHALL have port acc_sign  input  1  ACC bit 15; 1 means ACC is negative.
REQ-006 SHALL have port ctrl  output  16  control lines C0..C15 to the datapath; bit n is Cn.
REQ-007 SHALL have port alu_fn  output  8  ALU function code.
REQ-008 SHALL have port halted  output  1  high while in HALT.
REQ-009 SHALL have port instr_cnt  output  16  count of retired instructions.
REQ-010 SHALL have port state_dbg  output  4  current state encoding.

Function
REQ-011 SHALL be a Moore FSM; ctrl and alu_fn decode combinationally from the state register and the latched opcode only.
REQ-012 SHALL have states IDLE, F_MAR, F_READ, F_IR, DECODE, E_MAR, E_READ, E_BR, E_ALU, E_MBRW, E_WRITE, E_JUMP, HALT.
REQ-013 ctrl per state (all other bits 0): F_MAR C2; F_READ C0,C5,C15; F_IR C4; E_MAR C8; E_READ C0,C5; E_BR C6; E_ALU C9; E_MBRW C11; E_WRITE C0,C12; E_JUMP C3. IDLE, DECODE and HALT drive all zero.
REQ-014 Transitions: IDLE→F_MAR when start=1; F_MAR→F_READ→F_IR→DECODE unconditionally.
REQ-015 DECODE SHALL latch opcode into an internal op register; the outgoing transition depends on the opcode.
REQ-016 Opcodes 02,03,04,08,09,0A,0B,0C SHALL go DECODE→E_MAR→E_READ→E_BR→E_ALU→F_MAR (8 cycles per instruction).
REQ-017 Opcodes 0D,0E,0F SHALL go DECODE→E_ALU→F_MAR (5 cycles).
REQ-018 Opcode 01 (STORE) SHALL go DECODE→E_MAR→E_MBRW→E_WRITE→F_MAR.
REQ-019 Opcode 06 (JMP) SHALL go DECODE→E_JUMP→F_MAR.
REQ-020 Opcode 05 (JGE) SHALL sample acc_sign in DECODE: if 0, go to E_JUMP; if 1, go to F_MAR (PC already advanced by 2 in F_READ).
REQ-021 Opcode 07 SHALL go to HALT; HALT is absorbing and only rst exits it.
REQ-022 Undefined opcodes (00, 10..FF) SHALL act as a NOP: DECODE→F_MAR, retired and counted.
REQ-023 alu_fn SHALL equal the latched op in E_ALU and 00 in every other state.
REQ-024 Operand zeroing bits C7 and C14 SHALL stay 0 in all states.
REQ-025 instr_cnt SHALL increment by 1 on entry to F_MAR from any execute-terminal state or from DECODE (NOP/JGE not-taken); it SHALL NOT increment on IDLE→F_MAR.
REQ-026 instr_cnt SHALL saturate at FFFF.
REQ-027 Entry to HALT SHALL also increment instr_cnt (subject to saturation).
REQ-028 The start input is ignored outside IDLE.
REQ-029 halted SHALL equal (state==HALT).

Reset
REQ-030 rst SHALL asynchronously force state=IDLE, op=00 and instr_cnt=0, so ctrl=0000, alu_fn=00 and halted=0 during and immediately after reset.
REQ-031 rst asserted mid-instruction SHALL abandon the instruction with no further control pulses, and the abandoned instruction SHALL NOT be counted.

Structure
REQ-032 A shared package SHALL hold the state enum, the opcode constants 01..0F and the Cn bit-index constants.
REQ-033 The ctrl/alu_fn decode SHALL be one sub-module, cpu_ctrl_decode (purely combinational); the FSM and counter SHALL remain in cpu_sequencer.

Verification
REQ-034 Reset then start=1, opcode=03: ctrl sequence SHALL be 0004, 8021, 0010, 0000, 0100, 0021, 0040, 0200 (with alu_fn=03 in the last cycle), then F_MAR again; instr_cnt=1.
REQ-035 Opcode 01: after DECODE the ctrl sequence SHALL be 0100, 0800, 1001, then F_MAR.
REQ-036 Opcode 05 with acc_sign=0 SHALL produce E_JUMP with ctrl=0008; opcode 05 with acc_sign=1 SHALL go DECODE→F_MAR with no C3 pulse.
REQ-037 Opcode 07 SHALL set halted=1 and hold ctrl=0000 for 100 cycles despite start toggling; rst SHALL return the block to IDLE with instr_cnt=0.
REQ-038 Asserting rst in E_READ SHALL clear ctrl to 0000 asynchronously (same cycle) and leave instr_cnt unchanged.
REQ-039 Preloading the count to FFFE and running 3 NOPs (opcode 00) SHALL leave instr_cnt at FFFF.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the microcoded CPU sequencer:
// state encoding, opcode values, control-line bit positions and opcode classes.
package cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_F_MAR   = 4'd1,
    ST_F_READ  = 4'd2,
    ST_F_IR    = 4'd3,
    ST_DECODE  = 4'd4,
    ST_E_MAR   = 4'd5,
    ST_E_READ  = 4'd6,
    ST_E_BR    = 4'd7,
    ST_E_ALU   = 4'd8,
    ST_E_MBRW  = 4'd9,
    ST_E_WRITE = 4'd10,
    ST_E_JUMP  = 4'd11,
    ST_HALT    = 4'd12
  } state_e;

  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JGE   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'h07;
  localparam logic [7:0] OP_MPY   = 8'h08;
  localparam logic [7:0] OP_DIV   = 8'h09;
  localparam logic [7:0] OP_AND   = 8'h0A;
  localparam logic [7:0] OP_OR    = 8'h0B;
  localparam logic [7:0] OP_XOR   = 8'h0C;
  localparam logic [7:0] OP_NOT   = 8'h0D;
  localparam logic [7:0] OP_SHL   = 8'h0E;
  localparam logic [7:0] OP_SHR   = 8'h0F;

  localparam int C0  = 0;
  localparam int C1  = 1;
  localparam int C2  = 2;
  localparam int C3  = 3;
  localparam int C4  = 4;
  localparam int C5  = 5;
  localparam int C6  = 6;
  localparam int C7  = 7;
  localparam int C8  = 8;
  localparam int C9  = 9;
  localparam int C10 = 10;
  localparam int C11 = 11;
  localparam int C12 = 12;
  localparam int C13 = 13;
  localparam int C14 = 14;
  localparam int C15 = 15;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_MEM_ALU,
    CL_REG_ALU,
    CL_STORE,
    CL_JMP,
    CL_JGE,
    CL_HALT
  } op_class_e;

  // Anything not listed here retires as a NOP.
  function automatic op_class_e op_class(input logic [7:0] op);
    op_class_e cl;
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_MPY,
      OP_DIV, OP_AND, OP_OR, OP_XOR:   cl = CL_MEM_ALU;
      OP_NOT, OP_SHL, OP_SHR:          cl = CL_REG_ALU;
      OP_STORE:                        cl = CL_STORE;
      OP_JMP:                          cl = CL_JMP;
      OP_JGE:                          cl = CL_JGE;
      OP_HALT:                         cl = CL_HALT;
      default:                         cl = CL_NOP;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-to-datapath bundle; cnt_ld/cnt_ld_val preload the retired-instruction count.
interface cpu_sequencer_if;
  logic        start;
  logic [7:0]  opcode;
  logic        acc_sign;
  logic        cnt_ld;
  logic [15:0] cnt_ld_val;
  logic [15:0] ctrl;
  logic [7:0]  alu_fn;
  logic        halted;
  logic [15:0] instr_cnt;
  logic [3:0]  state_dbg;

  modport master (
    output start, opcode, acc_sign, cnt_ld, cnt_ld_val,
    input  ctrl, alu_fn, halted, instr_cnt, state_dbg
  );

  modport slave (
    input  start, opcode, acc_sign, cnt_ld, cnt_ld_val,
    output ctrl, alu_fn, halted, instr_cnt, state_dbg
  );
endinterface

// File: rtl/cpu_sequencer_ctrl_decode.sv
// Combinational control-word decode: state + latched opcode -> C0..C15 and ALU function.
module cpu_ctrl_decode
  import cpu_sequencer_pkg::*;
(
  input  state_e      state,
  input  logic [7:0]  op,
  output logic [15:0] ctrl,
  output logic [7:0]  alu_fn
);

  // C7 and C14 (operand zeroing) are never asserted by this sequencer.
  always_comb begin
    ctrl   = '0;
    alu_fn = '0;
    case (state)
      ST_F_MAR:   ctrl[C2] = 1'b1;
      ST_F_READ:  begin
        ctrl[C0]  = 1'b1;
        ctrl[C5]  = 1'b1;
        ctrl[C15] = 1'b1;
      end
      ST_F_IR:    ctrl[C4] = 1'b1;
      ST_E_MAR:   ctrl[C8] = 1'b1;
      ST_E_READ:  begin
        ctrl[C0] = 1'b1;
        ctrl[C5] = 1'b1;
      end
      ST_E_BR:    ctrl[C6] = 1'b1;
      ST_E_ALU:   begin
        ctrl[C9] = 1'b1;
        alu_fn   = op;
      end
      ST_E_MBRW:  ctrl[C11] = 1'b1;
      ST_E_WRITE: begin
        ctrl[C0]  = 1'b1;
        ctrl[C12] = 1'b1;
      end
      ST_E_JUMP:  ctrl[C3] = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer FSM with saturating retired-instruction counter.
// state | meaning: IDLE wait start; F_* fetch; DECODE latch op; E_* execute; HALT absorbing.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  cpu_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic        retire;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_F_MAR;
      ST_F_MAR:   state_d = ST_F_READ;
      ST_F_READ:  state_d = ST_F_IR;
      ST_F_IR:    state_d = ST_DECODE;
      ST_DECODE:  begin
        op_d = bus.opcode;
        case (op_class(bus.opcode))
          CL_MEM_ALU: state_d = ST_E_MAR;
          CL_REG_ALU: state_d = ST_E_ALU;
          CL_STORE:   state_d = ST_E_MAR;
          CL_JMP:     state_d = ST_E_JUMP;
          CL_JGE:     state_d = bus.acc_sign ? ST_F_MAR : ST_E_JUMP;
          CL_HALT:    state_d = ST_HALT;
          default:    state_d = ST_F_MAR;
        endcase
      end
      ST_E_MAR:   state_d = (op_q == OP_STORE) ? ST_E_MBRW : ST_E_READ;
      ST_E_READ:  state_d = ST_E_BR;
      ST_E_BR:    state_d = ST_E_ALU;
      ST_E_ALU:   state_d = ST_F_MAR;
      ST_E_MBRW:  state_d = ST_E_WRITE;
      ST_E_WRITE: state_d = ST_F_MAR;
      ST_E_JUMP:  state_d = ST_F_MAR;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The first fetch after IDLE is not a retirement; HALT entry is.
  always_comb begin
    retire = ((state_d == ST_F_MAR) && (state_q != ST_IDLE)) ||
             ((state_d == ST_HALT)  && (state_q != ST_HALT));
    cnt_d  = cnt_q;
    if (bus.cnt_ld)
      cnt_d = bus.cnt_ld_val;
    else if (retire && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  cpu_ctrl_decode u_decode (
    .state  (state_q),
    .op     (op_q),
    .ctrl   (bus.ctrl),
    .alu_fn (bus.alu_fn)
  );

  assign bus.halted    = (state_q == ST_HALT);
  assign bus.instr_cnt = cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: directed and random instruction streams against a per-opcode control-word model.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_cnt;
  logic [15:0] exp_ctrl[$];
  logic [7:0]  exp_alu[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Expected per-cycle control words for one instruction, starting at F_MAR.
  task automatic build_expected(input logic [7:0] op, input logic sign);
    exp_ctrl.delete();
    exp_alu.delete();
    exp_ctrl = '{16'h0004, 16'h8021, 16'h0010, 16'h0000};
    exp_alu  = '{8'h00, 8'h00, 8'h00, 8'h00};
    if (op inside {[8'h02:8'h04], [8'h08:8'h0C]}) begin
      exp_ctrl.push_back(16'h0100); exp_alu.push_back(8'h00);
      exp_ctrl.push_back(16'h0021); exp_alu.push_back(8'h00);
      exp_ctrl.push_back(16'h0040); exp_alu.push_back(8'h00);
      exp_ctrl.push_back(16'h0200); exp_alu.push_back(op);
    end else if (op inside {[8'h0D:8'h0F]}) begin
      exp_ctrl.push_back(16'h0200); exp_alu.push_back(op);
    end else if (op == 8'h01) begin
      exp_ctrl.push_back(16'h0100); exp_alu.push_back(8'h00);
      exp_ctrl.push_back(16'h0800); exp_alu.push_back(8'h00);
      exp_ctrl.push_back(16'h1001); exp_alu.push_back(8'h00);
    end else if (op == 8'h06 || (op == 8'h05 && !sign)) begin
      exp_ctrl.push_back(16'h0008); exp_alu.push_back(8'h00);
    end
  endtask

  // Entered with the DUT in F_MAR; leaves it in the next F_MAR (or HALT for opcode 07).
  task automatic run_instr(input logic [7:0] op, input logic sign);
    build_expected(op, sign);
    bus.opcode   = op;
    bus.acc_sign = sign;
    for (int i = 0; i < exp_ctrl.size(); i++) begin
      if (i >= 4) begin
        bus.opcode   = 8'($urandom);
        bus.acc_sign = 1'($urandom);
      end
      check($sformatf("ctrl op%h cyc%0d", op, i), bus.ctrl, exp_ctrl[i]);
      check($sformatf("alu_fn op%h cyc%0d", op, i), {8'h00, bus.alu_fn}, {8'h00, exp_alu[i]});
      check($sformatf("halted op%h cyc%0d", op, i), {15'h0, bus.halted}, 16'h0000);
      check($sformatf("cnt op%h cyc%0d", op, i), bus.instr_cnt, m_cnt);
      bus.start = 1'($urandom);
      step();
    end
    m_cnt = sat_inc(m_cnt);
    check($sformatf("cnt_after op%h", op), bus.instr_cnt, m_cnt);
    check($sformatf("halted_after op%h", op), {15'h0, bus.halted}, (op == 8'h07) ? 16'h0001 : 16'h0000);
    check($sformatf("ctrl_after op%h", op), bus.ctrl, (op == 8'h07) ? 16'h0000 : 16'h0004);
  endtask

  task automatic do_reset();
    bus.start  = 1'b0;
    bus.cnt_ld = 1'b0;
    rst = 1'b1;
    #2;
    check("rst ctrl", bus.ctrl, 16'h0000);
    check("rst alu_fn", {8'h00, bus.alu_fn}, 16'h0000);
    check("rst halted", {15'h0, bus.halted}, 16'h0000);
    check("rst cnt", bus.instr_cnt, 16'h0000);
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 16'h0000;
    step();
    check("idle ctrl", bus.ctrl, 16'h0000);
    check("idle cnt", bus.instr_cnt, 16'h0000);
  endtask

  task automatic go();
    bus.start = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] rop;
    bus.start      = 1'b0;
    bus.opcode     = 8'h00;
    bus.acc_sign   = 1'b0;
    bus.cnt_ld     = 1'b0;
    bus.cnt_ld_val = 16'h0000;
    rst            = 1'b1;
    m_cnt          = 16'h0000;
    #12;

    // Directed instruction classes
    do_reset();
    repeat (3) step();
    check("idle hold ctrl", bus.ctrl, 16'h0000);
    go();
    run_instr(8'h03, 1'b0);
    check("one retired", bus.instr_cnt, 16'h0001);
    run_instr(8'h01, 1'b0);
    run_instr(8'h05, 1'b0);
    run_instr(8'h05, 1'b1);
    run_instr(8'h06, 1'b1);
    run_instr(8'h0D, 1'b0);
    run_instr(8'h0F, 1'b1);
    run_instr(8'h00, 1'b0);
    run_instr(8'hA5, 1'b1);
    run_instr(8'h10, 1'b0);
    run_instr(8'hFF, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 3)
        rop = 8'($urandom_range(16, 255));
      else begin
        rop = 8'($urandom_range(0, 15));
        if (rop == 8'h07) rop = 8'h0C;
      end
      run_instr(rop, 1'($urandom));
    end

    // Reset in E_READ abandons the instruction
    do_reset();
    go();
    bus.opcode = 8'h02;
    repeat (5) step();
    check("e_read ctrl", bus.ctrl, 16'h0021);
    #2;
    rst = 1'b1;
    #1;
    check("midrst ctrl", bus.ctrl, 16'h0000);
    check("midrst alu_fn", {8'h00, bus.alu_fn}, 16'h0000);
    check("midrst cnt", bus.instr_cnt, 16'h0000);
    step();
    check("midrst hold ctrl", bus.ctrl, 16'h0000);
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 16'h0000;
    go();
    run_instr(8'h00, 1'b0);
    check("after abandon cnt", bus.instr_cnt, 16'h0001);

    // HALT is absorbing
    run_instr(8'h07, 1'b0);
    for (int n = 0; n < 100; n++) begin
      bus.start  = 1'($urandom);
      bus.opcode = 8'($urandom);
      step();
      check("halt halted", {15'h0, bus.halted}, 16'h0001);
      check("halt ctrl", bus.ctrl, 16'h0000);
      check("halt cnt", bus.instr_cnt, m_cnt);
    end
    do_reset();
    check("post-halt halted", {15'h0, bus.halted}, 16'h0000);

    // Counter saturation
    bus.cnt_ld     = 1'b1;
    bus.cnt_ld_val = 16'hFFFE;
    step();
    bus.cnt_ld = 1'b0;
    m_cnt      = 16'hFFFE;
    check("preload cnt", bus.instr_cnt, 16'hFFFE);
    go();
    repeat (3) run_instr(8'h00, 1'b0);
    check("saturated cnt", bus.instr_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
